// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the digit-serial magnitude comparator.
package serial_cmp_pkg;

  localparam int DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } cmp_state_t;

  typedef struct packed {
    logic l;
    logic e;
    logic g;
  } cmp_res_t;

endpackage

// File: rtl/quad_comparator4bit.sv
// One 4-bit comparator stage with cascade-in; the cascade is passed through
// only when the two digits are equal.
module quad_comparator4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       l,
  input  logic       e,
  input  logic       g,
  output logic       L,
  output logic       E,
  output logic       G
);

  always_comb begin
    L = l;
    E = e;
    G = g;
    if (a < b) begin
      L = 1'b1;
      E = 1'b0;
      G = 1'b0;
    end else if (a > b) begin
      L = 1'b0;
      E = 1'b0;
      G = 1'b1;
    end
  end

endmodule

// File: rtl/serial_hex_comparator.sv
// Digit-serial magnitude comparator that reuses one 4-bit stage over NIBBLES cycles.
// Define SERIAL_CMP_EARLY_TERM_EN for MSB-first processing with early termination.
module serial_hex_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             l,
  input  logic             e,
  input  logic             g,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             L,
  output logic             E,
  output logic             G,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / DIGIT;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  generate
    if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT) begin : g_width_check
      $error("serial_hex_comparator: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

`ifdef SERIAL_CMP_EARLY_TERM_EN
  localparam logic [CNT_W-1:0] IDX_FIRST = CNT_W'(NIBBLES - 1);
`else
  localparam logic [CNT_W-1:0] IDX_FIRST = '0;
`endif
  localparam logic [CNT_W-1:0] IDX_TOP = CNT_W'(NIBBLES - 1);

  cmp_state_t       state_q;
  logic [CNT_W-1:0] idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  cmp_res_t         res_q;
  logic             start_ready_q;
  logic             res_valid_q;
  logic             busy_q;

  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic             dig_l;
  logic             dig_e;
  logic             dig_g;
  logic             last_step;

  assign dig_a = a_q[int'(idx_q) * DIGIT +: DIGIT];
  assign dig_b = b_q[int'(idx_q) * DIGIT +: DIGIT];

  // Neutral cascade so the stage reports the raw relation of the current digit.
  quad_comparator4bit u_stage (
    .a (dig_a),
    .b (dig_b),
    .l (1'b0),
    .e (1'b1),
    .g (1'b0),
    .L (dig_l),
    .E (dig_e),
    .G (dig_g)
  );

`ifdef SERIAL_CMP_EARLY_TERM_EN
  assign last_step = !dig_e || (idx_q == '0);
`else
  assign last_step = (idx_q == IDX_TOP);
`endif

  // A differing digit overrides the running result; equal digits keep it, so the
  // cascade-in survives untouched only when every digit matches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      res_q         <= '0;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_q           <= a;
            b_q           <= b;
            res_q         <= cmp_res_t'({l, e, g});
            idx_q         <= IDX_FIRST;
            state_q       <= RUN;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
          end
        end
        RUN: begin
          if (!dig_e) begin
            res_q <= cmp_res_t'({dig_l, 1'b0, dig_g});
          end
          if (last_step) begin
            state_q     <= DONE;
            res_valid_q <= 1'b1;
          end else begin
`ifdef SERIAL_CMP_EARLY_TERM_EN
            idx_q <= idx_q - 1'b1;
`else
            idx_q <= idx_q + 1'b1;
`endif
          end
        end
        DONE: begin
          if (res_ready) begin
            state_q       <= IDLE;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= IDLE;
          res_valid_q   <= 1'b0;
          busy_q        <= 1'b0;
          start_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign busy        = busy_q;
  assign L           = res_q.l;
  assign E           = res_q.e;
  assign G           = res_q.g;

endmodule
